// File: rtl/com_pkg.sv
// Shared constants and state encoding for the command-frame consumer.
package com_pkg;

  localparam logic [7:0] SYNC1    = 8'hEB;
  localparam logic [7:0] SYNC2    = 8'h90;

  localparam logic [7:0] CMD_AUTO = 8'h00;
  localparam logic [7:0] CMD_FA   = 8'h01;
  localparam logic [7:0] CMD_FB   = 8'h02;
  localparam logic [7:0] CMD_RA   = 8'h03;
  localparam logic [7:0] CMD_RB   = 8'h04;
  localparam logic [7:0] NAK_CODE = 8'hEE;

  localparam int unsigned PULSE_W = 16;
  localparam int unsigned GAP_W   = 4;

  typedef enum logic [2:0] {
    ST_H1   = 3'd0,
    ST_H2   = 3'd1,
    ST_C    = 3'd2,
    ST_K    = 3'd3,
    ST_EXEC = 3'd4,
    ST_ACK  = 3'd5,
    ST_WAIT = 3'd6
  } state_t;

  // True for states that hold a partially received frame.
  function automatic logic in_frame(input state_t s);
    return (s == ST_H2) || (s == ST_C) || (s == ST_K);
  endfunction

endpackage

// File: rtl/com_pulse_gen.sv
// Reloadable down-counter: a fire strobe (re)starts a PULSE_LEN-cycle high pulse.
module com_pulse_gen
  import com_pkg::*;
#(
  parameter int unsigned PULSE_LEN = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_fire,
  output logic o_pulse
);

  logic [PULSE_W-1:0] r_cnt;
  logic [PULSE_W-1:0] w_cnt_nxt;
  logic               r_pulse;

  // Reload on fire so an overlapping command extends rather than stacks.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_fire) begin
      w_cnt_nxt = PULSE_W'(PULSE_LEN);
    end else if (r_cnt != '0) begin
      w_cnt_nxt = r_cnt - PULSE_W'(1);
    end
  end

  // Counter and registered pulse output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_pulse <= (w_cnt_nxt != '0);
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/com_identify.sv
// Command-frame consumer: hunts SYNC1/SYNC2/CMD/CHK frames in the receive FIFO,
// drives switch/reset controls and returns a 3-byte acknowledge to both CPUs.
module com_identify
  import com_pkg::*;
#(
  parameter int unsigned CNT_W     = 5,
  parameter logic [7:0]  SYNC1     = com_pkg::SYNC1,
  parameter logic [7:0]  SYNC2     = com_pkg::SYNC2,
  parameter int unsigned RST_PULSE = 50000,
  parameter int unsigned ACK_GAP   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rec_command,
  input  logic [CNT_W-1:0] com_count,
  input  logic             command_time_out,
  output logic             com_pop,
  output logic [7:0]       tdr_cpuAB,
  output logic             tf_push_cpuAB,
  output logic             force_swi,
  output logic             com_swi,
  output logic             error,
  output logic             reset_A,
  output logic             reset_B
);

  state_t             r_state, w_state_nxt;
  state_t             r_ret, w_ret_nxt;
  logic [7:0]         r_cmd, w_cmd_nxt;
  logic [7:0]         r_ack, w_ack_nxt;
  logic [1:0]         r_idx, w_idx_nxt;
  logic [GAP_W-1:0]   r_gap, w_gap_nxt;
  logic               r_force, w_force_nxt;
  logic               r_swi, w_swi_nxt;
  logic               r_err, w_err_nxt;
  logic               r_pop, w_pop_nxt;
  logic               r_push, w_push_nxt;
  logic [7:0]         r_tdr, w_tdr_nxt;
  logic               w_fire_a, w_fire_b;
  logic               w_have, w_in_frame;

  assign w_have     = (com_count != '0);
  assign w_in_frame = in_frame(r_state) || ((r_state == ST_WAIT) && in_frame(r_ret));

  // Next-state and next-output logic; every pop is followed by one WAIT clock.
  always_comb begin
    w_state_nxt = r_state;
    w_ret_nxt   = r_ret;
    w_cmd_nxt   = r_cmd;
    w_ack_nxt   = r_ack;
    w_idx_nxt   = r_idx;
    w_gap_nxt   = r_gap;
    w_force_nxt = r_force;
    w_swi_nxt   = r_swi;
    w_err_nxt   = r_err;
    w_pop_nxt   = 1'b0;
    w_push_nxt  = 1'b0;
    w_tdr_nxt   = r_tdr;
    w_fire_a    = 1'b0;
    w_fire_b    = 1'b0;

    if (command_time_out && w_in_frame) begin
      // Link went idle mid-frame: drop it, flag it, no acknowledge.
      w_state_nxt = ST_H1;
      w_err_nxt   = 1'b1;
    end else begin
      case (r_state)
        ST_H1: begin
          if (w_have) begin
            w_pop_nxt   = 1'b1;
            w_state_nxt = ST_WAIT;
            w_ret_nxt   = (rec_command == SYNC1) ? ST_H2 : ST_H1;
          end
        end
        ST_H2: begin
          if (w_have) begin
            w_pop_nxt   = 1'b1;
            w_state_nxt = ST_WAIT;
            if (rec_command == SYNC2)      w_ret_nxt = ST_C;
            else if (rec_command == SYNC1) w_ret_nxt = ST_H2;
            else                           w_ret_nxt = ST_H1;
          end
        end
        ST_C: begin
          if (w_have) begin
            w_pop_nxt   = 1'b1;
            w_state_nxt = ST_WAIT;
            w_ret_nxt   = ST_K;
            w_cmd_nxt   = rec_command;
          end
        end
        ST_K: begin
          if (w_have) begin
            w_pop_nxt   = 1'b1;
            w_state_nxt = ST_WAIT;
            w_idx_nxt   = 2'd0;
            w_gap_nxt   = '0;
            if ((rec_command == ~r_cmd) && (r_cmd <= CMD_RB)) begin
              w_ret_nxt = ST_EXEC;
            end else begin
              w_err_nxt = 1'b1;
              w_ack_nxt = NAK_CODE;
              w_ret_nxt = ST_ACK;
            end
          end
        end
        ST_EXEC: begin
          case (r_cmd)
            CMD_AUTO: w_force_nxt = 1'b0;
            CMD_FA: begin
              w_force_nxt = 1'b1;
              w_swi_nxt   = 1'b0;
            end
            CMD_FB: begin
              w_force_nxt = 1'b1;
              w_swi_nxt   = 1'b1;
            end
            CMD_RA:  w_fire_a = 1'b1;
            CMD_RB:  w_fire_b = 1'b1;
            default: ;
          endcase
          w_err_nxt   = 1'b0;
          w_ack_nxt   = r_cmd;
          w_idx_nxt   = 2'd0;
          w_gap_nxt   = '0;
          w_state_nxt = ST_ACK;
        end
        ST_ACK: begin
          if (r_gap == '0) begin
            w_push_nxt = 1'b1;
            if (r_idx == 2'd0)      w_tdr_nxt = SYNC1;
            else if (r_idx == 2'd1) w_tdr_nxt = SYNC2;
            else                    w_tdr_nxt = r_ack;
            w_gap_nxt = GAP_W'(ACK_GAP);
            if (r_idx == 2'd2) w_state_nxt = ST_H1;
            else               w_idx_nxt   = r_idx + 2'd1;
          end else begin
            w_gap_nxt = r_gap - GAP_W'(1);
          end
        end
        ST_WAIT: w_state_nxt = r_ret;
        default: w_state_nxt = ST_H1;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_H1;
      r_ret   <= ST_H1;
      r_cmd   <= '0;
      r_ack   <= '0;
      r_idx   <= '0;
      r_gap   <= '0;
      r_force <= 1'b0;
      r_swi   <= 1'b0;
      r_err   <= 1'b0;
      r_pop   <= 1'b0;
      r_push  <= 1'b0;
      r_tdr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ret   <= w_ret_nxt;
      r_cmd   <= w_cmd_nxt;
      r_ack   <= w_ack_nxt;
      r_idx   <= w_idx_nxt;
      r_gap   <= w_gap_nxt;
      r_force <= w_force_nxt;
      r_swi   <= w_swi_nxt;
      r_err   <= w_err_nxt;
      r_pop   <= w_pop_nxt;
      r_push  <= w_push_nxt;
      r_tdr   <= w_tdr_nxt;
    end
  end

  com_pulse_gen #(.PULSE_LEN(RST_PULSE)) u_pulse_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_fire  (w_fire_a),
    .o_pulse (reset_A)
  );

  com_pulse_gen #(.PULSE_LEN(RST_PULSE)) u_pulse_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_fire  (w_fire_b),
    .o_pulse (reset_B)
  );

  assign com_pop       = r_pop;
  assign tdr_cpuAB     = r_tdr;
  assign tf_push_cpuAB = r_push;
  assign force_swi     = r_force;
  assign com_swi       = r_swi;
  assign error         = r_err;

endmodule

// File: doc/com_identify.md
Name: com_identify

Overview:
- Command-frame consumer that sits on the receive side of the dual-CPU switch core.
- Pops bytes from the core's selected comm-port receive FIFO, hunts for and validates 4-byte command frames, then drives the core's switch and reset control inputs.
- Replies to both CPUs with a 3-byte acknowledge frame through the shared cpuA/cpuB transmit FIFOs.

Parameters:
- CNT_W, 5: width of com_count; equals UART_FIFO_COUNTER_W.
- SYNC1, 8'hEB: first frame byte.
- SYNC2, 8'h90: second frame byte.
- RST_PULSE, 50000: reset_A/reset_B pulse width in clk cycles, 1..65535.
- ACK_GAP, 2: idle clocks between successive tf_push_cpuAB pulses, 1..15.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- rec_command, input, 8: head byte of the core's selected receive FIFO; valid while com_count != 0.
- com_count, input, CNT_W: bytes held in that FIFO.
- command_time_out, input, 1: inter-frame idle gap detected on both comm links (level).
- com_pop, output, 1: one-cycle pop strobe to the FIFO.
- tdr_cpuAB, output, 8: byte to the CPU transmit FIFOs.
- tf_push_cpuAB, output, 1: one-cycle push strobe.
- force_swi, output, 1: commanded-switch enable (level).
- com_swi, output, 1: commanded target; 0 = CPU A, 1 = CPU B.
- error, output, 1: last frame was bad (level).
- reset_A, output, 1: reset pulse to CPU A.
- reset_B, output, 1: reset pulse to CPU B.

Behaviour:
- Reset values: all outputs 0; FSM in H1.
- Frame format: SYNC1, SYNC2, CMD, CHK, where CHK = ~CMD.
- Command codes:
  - 00: auto (force_swi <= 0).
  - 01: force to A (force_swi <= 1, com_swi <= 0).
  - 02: force to B (force_swi <= 1, com_swi <= 1).
  - 03: pulse reset_A.
  - 04: pulse reset_B.
  - Any other code: invalid.
- Byte fetch, shared by all receive states:
  - If com_count != 0: assert com_pop for 1 clk and latch rec_command in that same cycle.
  - Then spend 1 WAIT clk before sampling com_count again, so the FIFO count can update.
  - Result: at most 1 byte per 2 clks.
- FSM states: H1, H2, C, K, EXEC, ACK, plus WAIT after each pop.
  - H1: byte == SYNC1 -> H2; otherwise stay in H1 (silent discard, error unchanged).
  - H2: byte == SYNC2 -> C; byte == SYNC1 -> H2; otherwise -> H1.
  - C: latch CMD -> K.
  - K: if byte == ~CMD and CMD <= 04 -> EXEC; otherwise set error = 1 and load ack code 8'hEE -> ACK.
  - EXEC (1 clk):
    - Apply the command and clear error.
    - For 03/04: load a 16-bit down-counter with RST_PULSE and assert the matching reset for exactly RST_PULSE clks.
    - A reset command arriving while a pulse is running reloads the counter; the pulse is extended, never doubled.
    - Load ack code = CMD. Go to ACK.
  - ACK: push SYNC1, SYNC2, ack code; each push is a 1-clk tf_push_cpuAB with tdr_cpuAB stable on that clk; ACK_GAP idle clks between pushes. After the third push -> H1.
- Timeout and pop gating:
  - command_time_out high while in H2, C or K: abandon the frame, set error = 1, go to H1. No ack is sent.
  - command_time_out in H1 or ACK: ignored.
  - No pops occur in EXEC or ACK. Bytes stay in the FIFO.
- Output independence:
  - force_swi and com_swi hold their value until the next valid 00/01/02 command.
  - A reset command does not alter force_swi or com_swi.
- Asynchronous reset mid-frame or mid-pulse: immediate return to reset values; the partial frame is lost and any reset pulse ends.

Decomposition:
- Shared package com_pkg holds:
  - SYNC1 and SYNC2.
  - Command codes CMD_AUTO = 00, CMD_FA = 01, CMD_FB = 02, CMD_RA = 03, CMD_RB = 04.
  - NAK code 8'hEE.
  - FSM state encoding.
- One sub-module, com_pulse_gen: reloadable down-counter that produces reset_A/reset_B from the EXEC strobe. One instance per CPU.

Test Plan:
- Bytes EB 90 02 FD -> force_swi = 1, com_swi = 1, error = 0; tdr_cpuAB sequence EB, 90, 02, each push separated by 2 idle clks.
- Bytes EB 90 03 FC -> reset_A high for exactly RST_PULSE clks and reset_B stays 0. Send a second 03 frame mid-pulse -> pulse extended to RST_PULSE clks after the second EXEC.
- Bytes EB 90 01 00 (bad checksum) -> error = 1, force_swi unchanged, ack bytes EB 90 EE. Then EB 90 00 FF -> error = 0, force_swi = 0.
- Garbage 12 EB EB 90 01 FE -> resync on the second EB; force to A; exactly one ack is sent.
- EB 90, then command_time_out pulsed before the CMD byte -> error = 1, no ack, no pop while com_count = 0. The next valid frame is accepted.
- FIFO pre-loaded with 8 bytes (two frames) -> com_pop never on consecutive clks; both commands executed in order; 6 ack pushes; async rst_n asserted during the second ACK clears all outputs immediately.
